// File: rtl/bq_pkg.sv
// Shared widths, saturation bound helpers and stage payload type
// for the bias / ReLU / quantise pipeline.
package bq_pkg;

   localparam int ACC_W_D    = 18;
   localparam int BIAS_W_D   = 8;
   localparam int OUT_W_D    = 8;
   localparam int CHANNELS_D = 4;
   localparam int SHIFT_W_D  = 5;
   localparam int CNT_W_D    = 16;

   function automatic int sat_hi(input int out_w, input bit relu);
      return relu ? (1 << out_w) - 1 : (1 << (out_w - 1)) - 1;
   endfunction

   function automatic int sat_lo(input int out_w, input bit relu);
      return relu ? 0 : -(1 << (out_w - 1));
   endfunction

   typedef struct packed {
      logic signed [ACC_W_D:0]         sum;
      logic [$clog2(CHANNELS_D)-1:0]   ch;
      logic                            sat;
   } bq_stage_t;

endpackage

// File: rtl/bq_round_sat.sv
// Round-half-up arithmetic right shift followed by clamp to the
// output range; flags any beat that had to be clamped.
module bq_round_sat
   import bq_pkg::*;
#(
   parameter int ACC_W   = ACC_W_D,
   parameter int OUT_W   = OUT_W_D,
   parameter int SHIFT_W = SHIFT_W_D
) (
   input  logic signed [ACC_W:0]   sum,
   input  logic [SHIFT_W-1:0]      shift,
   input  logic                    relu_en,
   output logic [OUT_W-1:0]        q,
   output logic                    sat
);

   localparam int QW = ACC_W + 2;

   localparam logic signed [QW-1:0] U_HI = QW'(sat_hi(OUT_W, 1'b1));
   localparam logic signed [QW-1:0] U_LO = QW'(sat_lo(OUT_W, 1'b1));
   localparam logic signed [QW-1:0] S_HI = QW'(sat_hi(OUT_W, 1'b0));
   localparam logic signed [QW-1:0] S_LO = QW'(sat_lo(OUT_W, 1'b0));

   logic signed [QW-1:0] ext;
   logic signed [QW-1:0] rnd;
   logic signed [QW-1:0] acc;
   logic signed [QW-1:0] shq;
   logic signed [QW-1:0] hi;
   logic signed [QW-1:0] lo;
   logic signed [QW-1:0] clamped;
   logic                 big;

   assign ext = {sum[ACC_W], sum};
   assign big = int'(shift) > ACC_W;

   // Oversized shifts bypass the adder so the rounding term cannot
   // reach the sign bit; they collapse to 0 or -1.
   always_comb begin
      rnd = '0;
      if (shift != '0)
         rnd = QW'(1) << (shift - SHIFT_W'(1));
      acc = ext + rnd;
      shq = acc >>> shift;
      if (big)
         shq = ext[QW-1] ? '1 : '0;
   end

   assign hi = relu_en ? U_HI : S_HI;
   assign lo = relu_en ? U_LO : S_LO;

   always_comb begin
      clamped = shq;
      sat     = 1'b0;
      if (shq > hi) begin
         clamped = hi;
         sat     = 1'b1;
      end else if (shq < lo) begin
         clamped = lo;
         sat     = 1'b1;
      end
   end

   assign q = clamped[OUT_W-1:0];

endmodule

// File: rtl/bias_quant_pipe.sv
// Two-stage bias add / ReLU / quantise pipeline with a per-channel
// bias table, valid/ready on both sides and a saturation counter.
module bias_quant_pipe
   import bq_pkg::*;
#(
   parameter int ACC_W    = ACC_W_D,
   parameter int BIAS_W   = BIAS_W_D,
   parameter int OUT_W    = OUT_W_D,
   parameter int CHANNELS = CHANNELS_D,
   parameter int SHIFT_W  = SHIFT_W_D,
   parameter int CNT_W    = CNT_W_D,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_bias_we,
   input  logic [CH_W-1:0]          cfg_ch,
   input  logic signed [BIAS_W-1:0] cfg_bias,
   input  logic [SHIFT_W-1:0]       cfg_shift,
   input  logic                     cfg_relu_en,
   input  logic                     sat_clr,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [ACC_W-1:0]  in_acc,
   input  logic [CH_W-1:0]          in_ch,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         dout,
   output logic [CH_W-1:0]          dout_ch,
   output logic [CNT_W-1:0]         sat_count
);

   logic signed [BIAS_W-1:0] bias_q [CHANNELS];
   logic signed [BIAS_W-1:0] bias_rd;

   logic signed [ACC_W:0] sum_d;
   logic signed [ACC_W:0] s1_sum;
   logic signed [ACC_W:0] relu_sum;
   logic [CH_W-1:0]       s1_ch;
   logic                  s1_valid;

   logic                  s2_sat;
   logic                  s2_adv;
   logic                  accept;
   logic                  out_fire;
   logic [OUT_W-1:0]      rs_q;
   logic                  rs_sat;

   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;
   assign accept   = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // Registered table: a same-edge write is seen from the next accept on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++)
            bias_q[i] <= '0;
      end else if (cfg_bias_we && (int'(cfg_ch) < CHANNELS)) begin
         bias_q[cfg_ch] <= cfg_bias;
      end
   end

   assign bias_rd = (int'(in_ch) < CHANNELS) ? bias_q[in_ch] : '0;

   assign sum_d = {in_acc[ACC_W-1], in_acc}
                + {{(ACC_W+1-BIAS_W){bias_rd[BIAS_W-1]}}, bias_rd};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sum   <= '0;
         s1_ch    <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sum <= sum_d;
            s1_ch  <= in_ch;
         end
      end
   end

   assign relu_sum = (cfg_relu_en && s1_sum[ACC_W]) ? '0 : s1_sum;

   bq_round_sat #(
      .ACC_W   (ACC_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
   ) u_round_sat (
      .sum     (relu_sum),
      .shift   (cfg_shift),
      .relu_en (cfg_relu_en),
      .q       (rs_q),
      .sat     (rs_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         dout      <= '0;
         dout_ch   <= '0;
         s2_sat    <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            dout    <= rs_q;
            dout_ch <= s1_ch;
            s2_sat  <= rs_sat;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count <= '0;
      end else if (sat_clr) begin
         sat_count <= '0;
      end else if (out_fire && s2_sat && !(&sat_count)) begin
         sat_count <= sat_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_bias_quant_pipe.sv
// Directed self-checking bench for bias_quant_pipe with
// hand-computed expected results.
module tb_bias_quant_pipe;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cfg_bias_we;
   logic [1:0]        cfg_ch;
   logic signed [7:0] cfg_bias;
   logic [4:0]        cfg_shift;
   logic              cfg_relu_en;
   logic              sat_clr;
   logic              in_valid;
   logic              in_ready;
   logic signed [17:0] in_acc;
   logic [1:0]        in_ch;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        dout;
   logic [1:0]        dout_ch;
   logic [15:0]       sat_count;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   bias_quant_pipe dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_bias_we (cfg_bias_we),
      .cfg_ch      (cfg_ch),
      .cfg_bias    (cfg_bias),
      .cfg_shift   (cfg_shift),
      .cfg_relu_en (cfg_relu_en),
      .sat_clr     (sat_clr),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_acc      (in_acc),
      .in_ch       (in_ch),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .dout        (dout),
      .dout_ch     (dout_ch),
      .sat_count   (sat_count)
   );

   task automatic set_bias(input int ch, input int val);
      @(negedge clk);
      cfg_bias_we = 1'b1;
      cfg_ch      = 2'(ch);
      cfg_bias    = 8'(val);
      @(negedge clk);
      cfg_bias_we = 1'b0;
   endtask

   // lat = negedges from presenting the beat until out_valid seen
   task automatic run_beat(input int acc, input int ch,
                           output logic [7:0] d, output int lat);
      d   = '0;
      lat = -1;
      @(negedge clk);
      in_valid  = 1'b1;
      in_acc    = 18'(acc);
      in_ch     = 2'(ch);
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (out_valid) begin
            d   = dout;
            lat = i;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      #2;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || dout !== 8'd0 ||
          dout_ch !== 2'd0 || sat_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset: ov=%b ir=%b dout=%0d ch=%0d sc=%0d want 0 1 0 0 0",
                  out_valid, in_ready, dout, dout_ch, sat_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_latency;
      logic [7:0] d;
      int lat;
      cfg_relu_en = 1'b1;
      cfg_shift   = 5'd10;
      run_beat(65536, 0, d, lat);
      tests_run++;
      if (d !== 8'd64) begin
         tests_failed++;
         $display("FAIL lat_dout: got %0d want 64", d);
      end
      tests_run++;
      if (lat !== 2) begin
         tests_failed++;
         $display("FAIL latency: got %0d want 2", lat);
      end
      tests_run++;
      if (sat_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL lat_sat: got %0d want 0", sat_count);
      end
   endtask

   task automatic test_saturate_relu;
      logic [7:0] d;
      int lat;
      cfg_shift = 5'd8;
      set_bias(1, -128);
      run_beat(131071, 1, d, lat);
      tests_run++;
      if (d !== 8'd255) begin
         tests_failed++;
         $display("FAIL relu_sat: got %0d want 255", d);
      end
      tests_run++;
      if (sat_count !== 16'd1) begin
         tests_failed++;
         $display("FAIL relu_sat_cnt: got %0d want 1", sat_count);
      end
   endtask

   task automatic test_rounding;
      logic [7:0] d;
      int lat;
      run_beat(384, 0, d, lat);
      tests_run++;
      if (d !== 8'd2) begin
         tests_failed++;
         $display("FAIL round_384: got %0d want 2", d);
      end
      run_beat(383, 0, d, lat);
      tests_run++;
      if (d !== 8'd1) begin
         tests_failed++;
         $display("FAIL round_383: got %0d want 1", d);
      end
      run_beat(-1, 0, d, lat);
      tests_run++;
      if (d !== 8'd0) begin
         tests_failed++;
         $display("FAIL relu_neg: got %0d want 0", d);
      end
      tests_run++;
      if (sat_count !== 16'd1) begin
         tests_failed++;
         $display("FAIL round_cnt: got %0d want 1", sat_count);
      end
   endtask

   task automatic test_signed;
      logic [7:0] d;
      int lat;
      cfg_relu_en = 1'b0;
      cfg_shift   = 5'd8;
      run_beat(-131072, 1, d, lat);
      tests_run++;
      if (d !== 8'h80 || sat_count !== 16'd2) begin
         tests_failed++;
         $display("FAIL signed_min: got %0h cnt %0d want 80 cnt 2", d, sat_count);
      end
      run_beat(-256, 0, d, lat);
      tests_run++;
      if (d !== 8'hFF || sat_count !== 16'd2) begin
         tests_failed++;
         $display("FAIL signed_m1: got %0h cnt %0d want ff cnt 2", d, sat_count);
      end
   endtask

   task automatic test_shift_edges;
      logic [7:0] d;
      int lat;
      cfg_shift = 5'd19;
      run_beat(-5, 0, d, lat);
      tests_run++;
      if (d !== 8'hFF) begin
         tests_failed++;
         $display("FAIL big_shift_neg: got %0h want ff", d);
      end
      cfg_shift = 5'd31;
      run_beat(5, 0, d, lat);
      tests_run++;
      if (d !== 8'h00) begin
         tests_failed++;
         $display("FAIL big_shift_pos: got %0h want 0", d);
      end
      cfg_relu_en = 1'b1;
      cfg_shift   = 5'd0;
      run_beat(100, 0, d, lat);
      tests_run++;
      if (d !== 8'd100) begin
         tests_failed++;
         $display("FAIL shift0: got %0d want 100", d);
      end
      run_beat(300, 0, d, lat);
      tests_run++;
      if (d !== 8'd255 || sat_count !== 16'd3) begin
         tests_failed++;
         $display("FAIL shift0_sat: got %0d cnt %0d want 255 cnt 3", d, sat_count);
      end
   endtask

   task automatic test_hold_and_clr;
      bit seen;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_acc    = 18'(1000);
      in_ch     = 2'd3;
      @(negedge clk);
      in_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (!seen || out_valid !== 1'b1 || dout !== 8'd255 || dout_ch !== 2'd3) begin
         tests_failed++;
         $display("FAIL hold: ov=%b dout=%0d ch=%0d want 1 255 3",
                  out_valid, dout, dout_ch);
      end
      out_ready = 1'b1;
      sat_clr   = 1'b1;
      @(negedge clk);
      sat_clr = 1'b0;
      tests_run++;
      if (sat_count !== 16'd0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL clr_priority: cnt %0d ov %b want 0 0", sat_count, out_valid);
      end
   endtask

   task automatic test_back_to_back;
      int         acc_v [6] = '{256, 1000, 5120, -500, 70000, 640};
      int         ch_v  [6] = '{0, 1, 0, 1, 0, 3};
      logic [7:0] exp_v [6] = '{8'd1, 8'd3, 8'd20, 8'd0, 8'd255, 8'd3};
      bit         pat   [8] = '{0, 0, 0, 1, 0, 1, 1, 1};
      int  sent = 0;
      int  got  = 0;
      int  cyc  = 0;
      bit  stalled = 1'b0;
      bit  acc_now;
      cfg_relu_en = 1'b1;
      cfg_shift   = 5'd8;
      while (got < 6 && cyc < 60) begin
         @(negedge clk);
         in_valid  = (sent < 6);
         in_acc    = 18'(acc_v[(sent < 6) ? sent : 0]);
         in_ch     = 2'(ch_v[(sent < 6) ? sent : 0]);
         out_ready = (cyc < 8) ? pat[cyc] : 1'b1;
         #1;
         tests_run++;
         if (in_ready !== ((sent - got) < 2 || out_ready)) begin
            tests_failed++;
            $display("FAIL bp_in_ready: cyc %0d got %b occ %0d", cyc, in_ready, sent - got);
         end
         if (in_valid && !in_ready)
            stalled = 1'b1;
         acc_now = in_valid && in_ready;
         if (out_valid && out_ready) begin
            tests_run++;
            if (dout !== exp_v[got] || dout_ch !== 2'(ch_v[got])) begin
               tests_failed++;
               $display("FAIL bp_data[%0d]: got %0d/%0d want %0d/%0d",
                        got, dout, dout_ch, exp_v[got], ch_v[got]);
            end
            got++;
         end
         if (acc_now)
            sent++;
         cyc++;
      end
      in_valid = 1'b0;
      tests_run++;
      if (got != 6 || !stalled) begin
         tests_failed++;
         $display("FAIL bp_done: outputs %0d want 6, stalled %b want 1", got, stalled);
      end
      tests_run++;
      if (sat_count !== 16'd1) begin
         tests_failed++;
         $display("FAIL bp_cnt: got %0d want 1", sat_count);
      end
   endtask

   task automatic test_same_edge_bias;
      logic [7:0] res [2];
      int n = 0;
      cfg_shift = 5'd0;
      set_bias(2, 5);
      @(negedge clk);
      out_ready   = 1'b1;
      cfg_bias_we = 1'b1;
      cfg_ch      = 2'd2;
      cfg_bias    = 8'sd7;
      in_valid    = 1'b1;
      in_acc      = 18'(0);
      in_ch       = 2'd2;
      @(negedge clk);
      cfg_bias_we = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 10 && n < 2; i++) begin
         if (out_valid) begin
            res[n] = dout;
            n++;
         end
         @(negedge clk);
      end
      tests_run++;
      if (n != 2 || res[0] !== 8'd5 || res[1] !== 8'd7) begin
         tests_failed++;
         $display("FAIL same_edge_bias: n %0d got %0d,%0d want 5,7", n, res[0], res[1]);
      end
   endtask

   task automatic test_reset_midstream;
      logic [7:0] d;
      int  lat;
      bit  stale = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_acc    = 18'(1000);
      in_ch     = 2'd0;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || sat_count !== 16'd0 || in_ready !== 1'b1 ||
          dout !== 8'd0) begin
         tests_failed++;
         $display("FAIL mid_reset: ov %b cnt %0d ir %b dout %0d want 0 0 1 0",
                  out_valid, sat_count, in_ready, dout);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid)
            stale = 1'b1;
      end
      tests_run++;
      if (stale) begin
         tests_failed++;
         $display("FAIL stale_output: got out_valid after reset, want none");
      end
      run_beat(0, 2, d, lat);
      tests_run++;
      if (d !== 8'd0 || lat !== 2) begin
         tests_failed++;
         $display("FAIL bias_cleared: got %0d lat %0d want 0 lat 2", d, lat);
      end
   endtask

   initial begin
      rst_n       = 1'b1;
      cfg_bias_we = 1'b0;
      cfg_ch      = '0;
      cfg_bias    = '0;
      cfg_shift   = '0;
      cfg_relu_en = 1'b0;
      sat_clr     = 1'b0;
      in_valid    = 1'b0;
      in_acc      = '0;
      in_ch       = '0;
      out_ready   = 1'b0;
      #1 rst_n = 1'b0;
      test_reset;
      test_latency;
      test_saturate_relu;
      test_rounding;
      test_signed;
      test_shift_edges;
      test_hold_and_clr;
      test_back_to_back;
      test_same_edge_bias;
      test_reset_midstream;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
